// File: rtl/distribuidor_papeis_pkg.sv
// Shared game definitions for the role dealer: role codes, FSM state
// encoding and the widths used by the dealer datapath.
package distribuidor_papeis_pkg;

    localparam int unsigned PAPEL_W   = 2;
    localparam int unsigned JOGADOR_W = 3;

    // Role codes as they appear in each 2-bit slot of the game seed
    localparam logic [PAPEL_W-1:0] PAPEL_ALDEAO  = 2'b00;
    localparam logic [PAPEL_W-1:0] PAPEL_LOBO    = 2'b01;
    localparam logic [PAPEL_W-1:0] PAPEL_VIDENTE = 2'b10;
    localparam logic [PAPEL_W-1:0] PAPEL_MEDICO  = 2'b11;

    // Dealing round states
    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ESCONDIDO = 2'd1,
        MOSTRA    = 2'd2,
        FIM       = 2'd3
    } estado_t;

endpackage

// File: rtl/distribuidor_papeis_edge_detector.sv
// Registered rising-edge detector for the player button.
//   clock  : system clock
//   reset  : synchronous active-low reset
//   sinal  : button level, already synchronous to clock
//   pulso  : one-cycle pulse, one cycle after a 0->1 transition is sampled
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic historico;
    // Only armed once the button has been seen low after reset, so a button
    // held through reset release does not count as a press.
    logic armado;

    always_ff @(posedge clock) begin
        if (!reset) begin
            historico <= 1'b0;
            armado    <= 1'b0;
            pulso     <= 1'b0;
        end else begin
            historico <= sinal;
            armado    <= armado | ~sinal;
            pulso     <= sinal & ~historico & armado;
        end
    end

endmodule

// File: rtl/distribuidor_papeis.sv
// Role dealer: latches a game seed and shows each player's role in turn,
// alternating hidden/shown on every button press.
//   clock, reset : system clock, synchronous active-low reset
//   iniciar      : start pulse, latches jogo and starts a round
//   botao        : player button level
//   jogo         : game seed, player i role = jogo[2i+1:2i]
//   jogador      : current player index
//   papel        : role of current player (00 while not shown)
//   papel_valido : role currently visible
//   ocupado      : round in progress
//   pronto       : round finished
module distribuidor_papeis
    import distribuidor_papeis_pkg::*;
#(
    parameter int unsigned N_JOGADORES = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iniciar,
    input  logic                     botao,
    input  logic [2*N_JOGADORES-1:0] jogo,
    output logic [JOGADOR_W-1:0]     jogador,
    output logic [PAPEL_W-1:0]       papel,
    output logic                     papel_valido,
    output logic                     ocupado,
    output logic                     pronto
);

    localparam int unsigned          SEED_W = 2 * N_JOGADORES;
    localparam logic [JOGADOR_W-1:0] ULTIMO = JOGADOR_W'(N_JOGADORES - 1);

    estado_t           estado;
    estado_t           proximo;
    logic [SEED_W-1:0] semente;
    logic              pulso;
    logic              aceita_inicio;
    logic              avanca;
    logic [PAPEL_W-1:0] papel_atual;

    edge_detector u_edge_detector (
        .clock (clock),
        .reset (reset),
        .sinal (botao),
        .pulso (pulso)
    );

    // Start is honoured only outside a round; it wins over a coincident pulse
    always_comb begin
        aceita_inicio = iniciar && ((estado == OCIOSO) || (estado == FIM));
        avanca        = pulso && (estado == MOSTRA);
        papel_atual   = PAPEL_W'(semente >> {jogador, 1'b0});
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state logic
    always_comb begin
        proximo = estado;
        unique case (estado)
            OCIOSO: begin
                if (iniciar) proximo = ESCONDIDO;
            end
            ESCONDIDO: begin
                if (pulso) proximo = MOSTRA;
            end
            MOSTRA: begin
                if (pulso) proximo = (jogador == ULTIMO) ? FIM : ESCONDIDO;
            end
            FIM: begin
                if (iniciar) proximo = ESCONDIDO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    // Seed and player index; jogador stays at the last player once done
    always_ff @(posedge clock) begin
        if (!reset) begin
            semente <= '0;
            jogador <= '0;
        end else if (aceita_inicio) begin
            semente <= jogo;
            jogador <= '0;
        end else if (avanca && (jogador != ULTIMO)) begin
            jogador <= jogador + JOGADOR_W'(1);
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        papel        = PAPEL_ALDEAO;
        papel_valido = 1'b0;
        ocupado      = 1'b0;
        pronto       = 1'b0;
        unique case (estado)
            ESCONDIDO: begin
                ocupado = 1'b1;
            end
            MOSTRA: begin
                ocupado      = 1'b1;
                papel_valido = 1'b1;
                papel        = papel_atual;
            end
            FIM: begin
                pronto = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_distribuidor_papeis.sv
// Bench for the role dealer: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a round-progress model.
module tb_distribuidor_papeis;

    localparam int NJ = 5;

    logic            clock;
    logic            reset;
    logic            iniciar;
    logic            botao;
    logic [2*NJ-1:0] jogo;
    logic [2:0]      jogador;
    logic [1:0]      papel;
    logic            papel_valido;
    logic            ocupado;
    logic            pronto;

    int checks   = 0;
    int failures = 0;

    distribuidor_papeis #(.N_JOGADORES(NJ)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .botao        (botao),
        .jogo         (jogo),
        .jogador      (jogador),
        .papel        (papel),
        .papel_valido (papel_valido),
        .ocupado      (ocupado),
        .pronto       (pronto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: a round is a count of accepted presses (0..2*NJ); odd = role
    // shown, 2*NJ = finished. Presses come from the post-reset sample history.
    bit              m_ativo   = 1'b0;
    int              m_passo   = 0;
    logic [2*NJ-1:0] m_semente = '0;
    bit              m_hist[$];
    bit              m_pulso;

    always @(posedge clock) begin
        m_pulso = (m_hist.size() >= 2) && m_hist[m_hist.size()-1] && !m_hist[m_hist.size()-2];
        if (!reset) begin
            m_hist.delete();
            m_ativo   = 1'b0;
            m_passo   = 0;
            m_semente = '0;
        end else begin
            if (!m_ativo || m_passo == 2*NJ) begin
                if (iniciar) begin
                    m_semente = jogo;
                    m_passo   = 0;
                    m_ativo   = 1'b1;
                end
            end else if (m_pulso) begin
                m_passo++;
            end
            m_hist.push_back(botao);
            if (m_hist.size() > 4) void'(m_hist.pop_front());
        end
    end

    task automatic verifica(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: obtido=%0d esperado=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle, then compare every output with the model
    task automatic tick();
        int e_jog, e_val, e_pap, e_ocu, e_pro;
        @(posedge clock);
        @(negedge clock);
        e_jog = !m_ativo ? 0 : ((m_passo/2 < NJ) ? m_passo/2 : NJ-1);
        e_val = (m_ativo && (m_passo % 2 == 1)) ? 1 : 0;
        e_pap = e_val ? int'((m_semente >> (2*(m_passo/2))) & 3) : 0;
        e_ocu = (m_ativo && m_passo < 2*NJ) ? 1 : 0;
        e_pro = (m_ativo && m_passo == 2*NJ) ? 1 : 0;
        verifica("jogador", int'(jogador), e_jog);
        verifica("papel_valido", int'(papel_valido), e_val);
        verifica("papel", int'(papel), e_pap);
        verifica("ocupado", int'(ocupado), e_ocu);
        verifica("pronto", int'(pronto), e_pro);
    endtask

    task automatic press();
        botao = 1'b1;
        tick();
        botao = 1'b0;
        tick();
    endtask

    task automatic start(input logic [2*NJ-1:0] semente);
        jogo    = semente;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    int papeis_391[5] = '{1, 0, 1, 2, 3};

    initial begin
        reset   = 1'b0;
        iniciar = 1'b0;
        botao   = 1'b1;
        jogo    = '0;

        // Reset held with button high, then released with button still high
        repeat (3) tick();
        verifica("rst_ocupado", int'(ocupado), 0);
        verifica("rst_pronto", int'(pronto), 0);
        reset = 1'b1;
        repeat (3) tick();
        verifica("rel_ocupado", int'(ocupado), 0);
        verifica("rel_jogador", int'(jogador), 0);

        // Full round with seed 0x391
        botao = 1'b0;
        tick();
        start(10'h391);
        verifica("ini_ocupado", int'(ocupado), 1);
        for (int k = 0; k < NJ; k++) begin
            press();
            verifica("r391_valido", int'(papel_valido), 1);
            verifica("r391_jogador", int'(jogador), k);
            verifica("r391_papel", int'(papel), papeis_391[k]);
            press();
        end
        verifica("fim_pronto", int'(pronto), 1);
        verifica("fim_ocupado", int'(ocupado), 0);
        verifica("fim_jogador", int'(jogador), NJ-1);

        // Restart from FIM; held button on player 1 advances exactly once
        start(10'h391);
        press();
        press();
        press();
        verifica("hold_pre_jog", int'(jogador), 1);
        botao = 1'b1;
        repeat (20) tick();
        botao = 1'b0;
        tick();
        verifica("hold_jogador", int'(jogador), 2);
        verifica("hold_valido", int'(papel_valido), 0);

        // Seed input changed mid-round has no effect
        jogo = '0;
        press();
        verifica("latch_papel2", int'(papel), 1);
        press();
        press();
        verifica("latch_papel3", int'(papel), 2);
        verifica("latch_jog3", int'(jogador), 3);

        // Reset while showing player 3
        reset = 1'b0;
        tick();
        verifica("mid_rst_valido", int'(papel_valido), 0);
        verifica("mid_rst_ocupado", int'(ocupado), 0);
        verifica("mid_rst_jogador", int'(jogador), 0);
        reset = 1'b1;
        tick();
        start(10'h391);
        verifica("restart_jog", int'(jogador), 0);
        verifica("restart_ocupado", int'(ocupado), 1);
        repeat (2*NJ) press();
        verifica("fim2_pronto", int'(pronto), 1);

        // Start and button pulse coincide in FIM: start wins
        botao = 1'b1;
        tick();
        jogo    = 10'h2AA;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        botao   = 1'b0;
        verifica("coinc_ocupado", int'(ocupado), 1);
        verifica("coinc_jogador", int'(jogador), 0);
        verifica("coinc_valido", int'(papel_valido), 0);
        tick();
        press();
        verifica("coinc_papel", int'(papel), 2);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 99) != 0);
            iniciar = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 2) == 0) botao = ~botao;
            jogo = (2*NJ)'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
